// File: rtl/ifu_pkg.sv
// ----------------------------------------------------------------------------
// ifu_pkg: shared types and constants for the LemonPC instruction fetch unit.
//   - ifu_state_e : fetch FSM state encoding (2 bits)
//   - INST_NOP    : instruction presented before the first fetch completes
//   - PC_RESET    : default reset PC
//   - pc_aligned  : word-alignment check (no compressed ISA, so bits [1:0])
// ----------------------------------------------------------------------------
package ifu_pkg;

    typedef enum logic [1:0] {
        StReq   = 2'b00,
        StWait  = 2'b01,
        StHold  = 2'b10,
        StFault = 2'b11
    } ifu_state_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;
    localparam int unsigned CNT_W    = 8;

    function automatic logic pc_aligned(input logic [63:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_if.sv
// ----------------------------------------------------------------------------
// ifu_if: bundle of the fetch unit's instruction-memory port and its
// decode/execute-facing port.
//   imem_req_valid/imem_req_ready/imem_addr : fetch request (valid/ready)
//   imem_resp_valid/imem_resp_data          : fetch response (valid only)
//   inst_valid/inst/pc                      : instruction handed to decode
//   inst_ready/redirect_valid/redirect_pc   : retire and next-PC control
//   fetch_fault                             : sticky fault flag
// Modport master is the fetch unit; slave is the surrounding core/memory.
// ----------------------------------------------------------------------------
interface ifu_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_fault;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_addr,
        input  imem_resp_valid,
        input  imem_resp_data,
        output inst_valid,
        output inst,
        output pc,
        input  inst_ready,
        input  redirect_valid,
        input  redirect_pc,
        output fetch_fault
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_addr,
        output imem_resp_valid,
        output imem_resp_data,
        input  inst_valid,
        input  inst,
        input  pc,
        output inst_ready,
        output redirect_valid,
        output redirect_pc,
        input  fetch_fault
    );

endinterface

// File: rtl/ifu.sv
// ----------------------------------------------------------------------------
// ifu: instruction fetch unit for the single-cycle LemonPC core.
// Owns the architectural PC, issues one word fetch at a time, holds the
// fetched instruction until execute retires it, then advances to pc+4 or
// to the redirect target.
// Ports:
//   clk  : core clock
//   rst  : synchronous, active-high reset
//   bus  : ifu_if.master (imem request/response, decode/execute handshake,
//          sticky fetch_fault)
// Parameters:
//   RESET_PC : PC loaded on reset
//   TIMEOUT  : cycles to wait for an imem response before faulting (1..255)
// ----------------------------------------------------------------------------
module ifu
    import ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = PC_RESET,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic  clk,
    input  logic  rst,
    ifu_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    ifu_state_e       r_state,      w_state_nxt;
    logic [63:0]      r_pc,         w_pc_nxt;
    logic [31:0]      r_inst,       w_inst_nxt;
    logic             r_inst_valid, w_inst_valid_nxt;
    logic [CNT_W-1:0] r_cnt,        w_cnt_nxt;
    logic             w_pc_ok;

    assign w_pc_ok = pc_aligned(r_pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StReq;
            r_pc         <= RESET_PC;
            r_inst       <= INST_NOP;
            r_inst_valid <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_nxt       = r_inst;
        w_inst_valid_nxt = r_inst_valid;
        w_cnt_nxt        = r_cnt;

        case (r_state)
            StReq: begin
                // A misaligned PC (reset value or redirect target) never
                // reaches memory; it parks in the fault state for debug.
                if (!w_pc_ok) begin
                    w_state_nxt = StFault;
                end else if (bus.imem_req_ready) begin
                    w_state_nxt = StWait;
                    w_cnt_nxt   = '0;
                end
            end
            StWait: begin
                if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                // A response landing on the last allowed cycle still wins.
                if (bus.imem_resp_valid) begin
                    w_inst_nxt       = bus.imem_resp_data;
                    w_inst_valid_nxt = 1'b1;
                    w_state_nxt      = StHold;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = StFault;
                end
            end
            StHold: begin
                if (bus.inst_ready) begin
                    w_pc_nxt         = bus.redirect_valid ? bus.redirect_pc : r_pc + 64'd4;
                    w_inst_valid_nxt = 1'b0;
                    w_state_nxt      = StReq;
                end
            end
            StFault: begin
                w_inst_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = StFault;
            end
        endcase
    end

    assign bus.imem_req_valid = (r_state == StReq) && w_pc_ok;
    assign bus.imem_addr      = r_pc;
    assign bus.inst_valid     = r_inst_valid;
    assign bus.inst           = r_inst;
    assign bus.pc             = r_pc;
    assign bus.fetch_fault    = (r_state == StFault);

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit for the single-cycle LemonPC core; sits directly upstream of the control/decode stage and drives its instruction input.
- Owns the architectural PC and issues one outstanding word fetch at a time over a valid/ready request, valid-only response instruction-memory port.
- Holds the fetched instruction stable until execute consumes it.
- On consumption, takes the next PC from execute's redirect (jal/jalr) or PC+4.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- TIMEOUT, 16, max cycles to wait for an imem response before faulting (1..255).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  imem accepts request this cycle
- imem_addr  out  64  fetch address (= pc)
- imem_resp_valid  in  1  fetch data valid, single-cycle pulse
- imem_resp_data  in  32  fetched instruction word
- inst_valid  out  1  inst/pc valid for decode
- inst  out  32  held instruction word
- pc  out  64  PC of inst / current fetch address
- inst_ready  in  1  execute retires inst this cycle
- redirect_valid  in  1  take redirect_pc instead of pc+4; sampled only on retire
- redirect_pc  in  64  jump/branch target from ALU
- fetch_fault  out  1  sticky fault flag: misaligned PC or response timeout

Behaviour:
- All state registered on posedge clk. rst is synchronous; it overrides everything, including mid-fetch.
- Reset values:
  - pc=RESET_PC, state=S_REQ, inst=32'h0000_0013 (nop), inst_valid=0, fetch_fault=0, timeout counter=0.
  - imem_req_valid is combinational from state, so it is 1 in the first cycle after rst drops.
- States:
  - S_REQ: imem_req_valid=1, imem_addr=pc. If pc[1:0]!=0, go to S_FAULT without asserting imem_req_valid. Else if imem_req_ready, go to S_WAIT and clear the counter.
  - S_WAIT: counter increments each cycle.
    - If imem_resp_valid: inst<=imem_resp_data, inst_valid<=1, go to S_HOLD.
    - Else if counter==TIMEOUT-1, go to S_FAULT.
  - S_HOLD: inst_valid=1; inst and pc are frozen.
    - On inst_ready: pc <= redirect_valid ? redirect_pc : pc+64'd4 (mod 2^64, wraps); inst_valid<=0; go to S_REQ.
  - S_FAULT: fetch_fault=1, inst_valid=0, imem_req_valid=0. Only rst exits this state.
- Response rules:
  - A response is never accepted in the same cycle as its request.
  - imem_resp_valid in S_REQ, S_HOLD or S_FAULT is ignored, and nothing in ifu changes.
- Latency:
  - Request accepted in cycle N, response in cycle N+k (k>=1) -> inst_valid in cycle N+k+1.
  - Retire in cycle T -> next request in cycle T+1.
  - Minimum retire-to-retire spacing is 3 cycles.
- Misalignment is checked only on bits [1:0] (no compressed ISA). The check applies to both the reset PC and redirect targets.
- inst_ready while inst_valid=0 is ignored. redirect_valid is never sampled outside a retire.
- Misaligned redirect: pc is still updated to the target. The fault is raised in the following S_REQ cycle, and pc holds the offending value for debug.
- Counter is 8 bits and saturates; it is compared only in S_WAIT.

Decomposition:
- Add to defines.v:
  - state encodings `ifu_s_req, `ifu_s_wait, `ifu_s_hold, `ifu_s_fault (2-bit)
  - `inst_nop 32'h0000_0013
  - `pc_reset 64'h8000_0000, used as the default of RESET_PC
- The existing `true/`false are reused.
- No sub-module is required. The timeout counter stays inline; it is small and state-coupled.

Test Plan:
- Reset release, imem_req_ready=1, response 1 cycle later with 32'h00000513:
  - cycle 1: imem_req_valid=1, imem_addr=0x80000000
  - cycle 3: inst_valid=1, inst=0x00000513, pc=0x80000000
- Hold inst_ready=0 for 10 cycles while imem_resp_valid pulses spuriously with 0xDEADBEEF -> inst stays 0x00000513, no new request issued.
- Retire without redirect -> pc=0x80000004, request at T+1. Retire with redirect_valid=1, redirect_pc=0x80000100 -> next imem_addr=0x80000100.
- Redirect to 0x80000102 -> pc=0x80000102, fetch_fault=1 one cycle later, imem_req_valid never asserted, inst_valid=0 until rst.
- TIMEOUT=16, request accepted, no response -> fetch_fault=1 after 16 cycles in S_WAIT. Assert rst mid-wait in a second run -> next cycle pc=0x80000000, fault clear, new request issued.
- Hold imem_req_ready=0 for 5 cycles -> imem_req_valid and imem_addr stable throughout; accepted on the 6th cycle.
